// File: rtl/label_gate_fifo.sv
// label_gate_fifo: show-ahead label/data FIFO feeding a low-security channel.
// H-labelled entries are scrubbed to zero or dropped at the head, and counted.
module label_gate_fifo #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 4,
   parameter int CNT_W     = 8,
   parameter bit DROP_HIGH = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_lbl,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic                    out_scrubbed,
   output logic [CNT_W-1:0]        scrub_cnt,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_W:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            head_lbl, nonempty, push, pop;
   assign nonempty     = count != '0;
   assign head_lbl     = mem[rd_ptr][DATA_W];
   assign in_ready     = count < (AW+1)'(DEPTH);
   assign push         = in_valid & in_ready;
   assign out_valid    = nonempty & ~(DROP_HIGH & head_lbl);
   assign out_scrubbed = nonempty & head_lbl & ~DROP_HIGH;
   // data is gated on occupancy too, so stale H words in storage never leak while idle
   assign out_data     = (nonempty & ~head_lbl) ? mem[rd_ptr][DATA_W-1:0] : '0;
   assign pop          = nonempty & (out_ready | (DROP_HIGH & head_lbl));
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {in_lbl, in_data};
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         scrub_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (pop & head_lbl & (scrub_cnt != '1)) scrub_cnt <= scrub_cnt + 1'b1;
      end
endmodule

// File: tb/tb_label_gate_fifo.sv
// tb_label_gate_fifo: scrub variant (CNT_W=2) and drop variant (DROP_HIGH=1) share
// one stimulus stream; a queue-based scoreboard checks both every cycle.
module tb_label_gate_fifo;
   logic       clk = 0, rst = 0;
   logic       in_valid = 0, in_lbl = 0, out_ready = 0;
   logic [7:0] in_data = 0;
   logic       in_ready_a, out_valid_a, out_scrubbed_a, in_ready_b, out_valid_b, out_scrubbed_b;
   logic [7:0] out_data_a, out_data_b, scrub_b;
   logic [1:0] scrub_a;
   logic [2:0] count_a, count_b;
   int         errors = 0, checks = 0;
   logic [8:0] qa[$], qb[$];
   int         sca = 0, scb = 0;
   bit         pa, pb, oa, ob;

   always #5 clk = ~clk;

   label_gate_fifo #(.DATA_W(8), .DEPTH(4), .CNT_W(2), .DROP_HIGH(1'b0)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_lbl(in_lbl),
      .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
      .out_scrubbed(out_scrubbed_a), .scrub_cnt(scrub_a), .count(count_a));

   label_gate_fifo #(.DATA_W(8), .DEPTH(4), .CNT_W(8), .DROP_HIGH(1'b1)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_lbl(in_lbl),
      .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
      .out_scrubbed(out_scrubbed_b), .scrub_cnt(scrub_b), .count(count_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      rst = 0;
      #1;
      chk("async_rst_cnt_a", count_a, 0);
      chk("async_rst_vld_a", out_valid_a, 0);
      chk("async_rst_dat_a", out_data_a, 0);
      chk("async_rst_cnt_b", count_b, 0);
      step();
      rst = 1;
   endtask

   // Scoreboard: queues hold the expected presentation {scrubbed, data} of each accepted pair
   always @(negedge clk) begin
      if (!rst) begin
         qa.delete();
         qb.delete();
         sca = 0;
         scb = 0;
         chk("rst_vld_a", out_valid_a, 0);
         chk("rst_dat_a", out_data_a, 0);
         chk("rst_scr_a", out_scrubbed_a, 0);
         chk("rst_rdy_b", in_ready_b, 1);
      end else begin
         chk("cnt_a", count_a, qa.size());
         chk("rdy_a", in_ready_a, qa.size() < 4);
         chk("vld_a", out_valid_a, qa.size() != 0);
         chk("dat_a", out_data_a, qa.size() != 0 ? qa[0][7:0] : 8'h0);
         chk("scr_a", out_scrubbed_a, qa.size() != 0 ? qa[0][8] : 1'b0);
         chk("scnt_a", scrub_a, sca);
         chk("cnt_b", count_b, qb.size());
         chk("rdy_b", in_ready_b, qb.size() < 4);
         chk("vld_b", out_valid_b, qb.size() != 0 && !qb[0][8]);
         chk("dat_b", out_data_b, qb.size() != 0 ? qb[0][7:0] : 8'h0);
         chk("scr_b", out_scrubbed_b, 0);
         chk("scnt_b", scrub_b, scb);
         pa = in_valid && qa.size() < 4;
         pb = in_valid && qb.size() < 4;
         oa = qa.size() != 0 && out_ready;
         ob = qb.size() != 0 && (out_ready || qb[0][8]);
         if (oa) begin
            if (qa[0][8] && sca < 3) sca++;
            void'(qa.pop_front());
         end
         if (ob) begin
            if (qb[0][8] && scb < 255) scb++;
            void'(qb.pop_front());
         end
         if (pa) qa.push_back({in_lbl, in_lbl ? 8'h0 : in_data});
         if (pb) qb.push_back({in_lbl, in_lbl ? 8'h0 : in_data});
      end
   end

   initial begin
      repeat (2) step();
      chk("reset_cnt", count_a, 0);
      chk("reset_rdy", in_ready_a, 1);
      chk("reset_scnt", scrub_a, 0);
      rst = 1;
      // first-word latency and asynchronous reset
      in_valid = 1; in_lbl = 0; in_data = 8'h5A;
      #1 chk("no_passthru", out_valid_a, 0);
      step();
      in_valid = 0;
      chk("lat_vld", out_valid_a, 1);
      chk("lat_dat", out_data_a, 8'h5A);
      chk("lat_scr", out_scrubbed_a, 0);
      chk("lat_cnt", count_a, 1);
      rst_pulse();
      // scrub then pass
      out_ready = 1;
      in_valid = 1; in_lbl = 1; in_data = 8'hFF;
      step();
      chk("h_dat", out_data_a, 0);
      chk("h_scr", out_scrubbed_a, 1);
      in_lbl = 0; in_data = 8'h11;
      step();
      in_valid = 0;
      chk("l_dat", out_data_a, 8'h11);
      step();
      chk("scnt_one", scrub_a, 1);
      chk("scnt_one_b", scrub_b, 1);
      // fill, blocked push, no full-bypass, wrap
      out_ready = 0; in_valid = 1;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'h20 + 8'(i);
         step();
      end
      chk("full_rdy", in_ready_a, 0);
      in_data = 8'h99;
      step();
      chk("full_cnt", count_a, 4);
      out_ready = 1; in_data = 8'h30;
      chk("no_bypass", in_ready_a, 0);
      step();
      chk("pop_cnt", count_a, 3);
      for (int i = 0; i < 6; i++) begin
         in_data = 8'h40 + 8'(i);
         step();
      end
      chk("pp_cnt", count_a, 3);
      in_valid = 0;
      repeat (4) step();
      chk("drain_cnt", count_a, 0);
      // drop variant: consecutive H drain
      rst_pulse();
      out_ready = 0; in_valid = 1; in_lbl = 1; in_data = 8'h01;
      step();
      in_data = 8'h02;
      step();
      in_lbl = 0; in_data = 8'h33;
      step();
      in_valid = 0;
      chk("drop_vld", out_valid_b, 1);
      chk("drop_dat", out_data_b, 8'h33);
      chk("drop_scnt", scrub_b, 2);
      // saturation on the 2-bit counter
      rst_pulse();
      out_ready = 1; in_valid = 1; in_lbl = 1;
      for (int i = 0; i < 5; i++) begin
         in_data = 8'hA0 + 8'(i);
         step();
         if (i == 3) chk("sat_third", scrub_a, 3);
      end
      in_valid = 0;
      step();
      chk("sat_final", scrub_a, 3);
      chk("sat_cnt", count_a, 0);
      chk("nosat_b", scrub_b, 5);
      // random traffic, checked by the scoreboard
      for (int i = 0; i < 10000; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_lbl = 1'($urandom_range(0, 1));
         in_data = 8'($urandom);
         out_ready = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 999) == 0) rst_pulse();
         else step();
      end
      in_valid = 0;
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
